// File: rtl/vend_ctrl_multi_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vend_ctrl_multi_if : coin/select/refund inputs and display/change
//                      outputs of the vending controller
// Rev 1.0
// ------------------------------------------------------------------
interface vend_ctrl_multi_if #(
  parameter int unsigned N_ITEMS = 3
);
  logic                   halfyuan_i;
  logic                   oneyuan_i;
  logic [N_ITEMS-1:0]     sell_i;
  logic                   supply_i;
  logic                   coin_return_i;
  logic [15:0]            display_o;
  logic [4*N_ITEMS-1:0]   stock_out_o;
  logic [N_ITEMS-1:0]     vend_led_o;
  logic                   change_vld_o;
  logic [15:0]            change_amt_o;
  logic                   coin_rej_o;

  // Controller side
  modport slave (
    input  halfyuan_i, oneyuan_i, sell_i, supply_i, coin_return_i,
    output display_o, stock_out_o, vend_led_o, change_vld_o, change_amt_o, coin_rej_o
  );

  // Panel / environment side
  modport master (
    output halfyuan_i, oneyuan_i, sell_i, supply_i, coin_return_i,
    input  display_o, stock_out_o, vend_led_o, change_vld_o, change_amt_o, coin_rej_o
  );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ------------------------------------------------------------------
// vend_ctrl_multi : N-item BCD vending controller with change-out
//                   and timed NOFUNDS / SOLDOUT messages
// Rev 1.0
// ------------------------------------------------------------------
module vend_ctrl_multi #(
  parameter int unsigned            N_ITEMS    = 3,
  parameter logic [16*N_ITEMS-1:0]  PRICE      = {16'h0035, 16'h0030, 16'h0020},
  parameter logic [3:0]             STOCK_INIT = 4'd5,
  parameter logic [15:0]            MONEY_MAX  = 16'h9995,
  parameter logic [26:0]            MSG_CYCLES = 27'd100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  vend_ctrl_multi_if.slave   bus_io
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_NOFUNDS = 2'd1,
    S_SOLDOUT = 2'd2
  } state_e;

  // 4-digit packed BCD add; bit 16 is the decimal carry out of the top digit
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      s = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*d +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // 4-digit packed BCD subtract; callers guarantee a >= b
  function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        br;
    logic [15:0] r;
    br = 1'b0;
    r  = '0;
    for (int d = 0; d < 4; d++) begin
      s = {1'b0, a[4*d +: 4]} - {1'b0, b[4*d +: 4]} - {4'b0000, br};
      if (s[4]) begin
        s  = s + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      r[4*d +: 4] = s[3:0];
    end
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [26:0]          timer_q, timer_d;
  logic [15:0]          bal_q, bal_d;
  logic [4*N_ITEMS-1:0] stock_q, stock_d;
  logic [7:0]           msg_q, msg_d;
  logic [N_ITEMS-1:0]   vend_q, vend_d;
  logic                 chg_vld_q, chg_vld_d;
  logic [15:0]          chg_amt_q, chg_amt_d;
  logic                 rej_q, rej_d;

  logic                 half_prev_q, one_prev_q, sup_prev_q, ret_prev_q;
  logic [N_ITEMS-1:0]   sell_prev_q;

  logic                 half_rise, one_rise, sup_rise, ret_rise;
  logic [N_ITEMS-1:0]   sell_rise;
  logic [16:0]          coin_sum;
  logic                 sell_found;

  assign half_rise = bus_io.halfyuan_i    & ~half_prev_q;
  assign one_rise  = bus_io.oneyuan_i     & ~one_prev_q;
  assign sup_rise  = bus_io.supply_i      & ~sup_prev_q;
  assign ret_rise  = bus_io.coin_return_i & ~ret_prev_q;
  assign sell_rise = bus_io.sell_i        & ~sell_prev_q;

  // One-yuan outranks half-yuan, so only the winning coin value is summed
  assign coin_sum  = bcd_add(bal_q, one_rise ? 16'h0010 : 16'h0005);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bal_d      = bal_q;
    stock_d    = stock_q;
    msg_d      = msg_q;
    vend_d     = vend_q;
    chg_vld_d  = 1'b0;
    chg_amt_d  = chg_amt_q;
    rej_d      = 1'b0;
    sell_found = 1'b0;

    if (state_q != S_IDLE) begin
      if (timer_q <= 27'd1) begin
        state_d = S_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q - 27'd1;
      end
    end

    if (ret_rise) begin
      chg_amt_d = bal_q;
      chg_vld_d = 1'b1;
      bal_d     = '0;
      vend_d    = '0;
      state_d   = S_IDLE;
      timer_d   = '0;
    end else if (sup_rise) begin
      stock_d   = {N_ITEMS{STOCK_INIT}};
      vend_d    = '0;
      state_d   = S_IDLE;
      timer_d   = '0;
    end else if (|sell_rise) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (!sell_found && sell_rise[i]) begin
          sell_found = 1'b1;
          vend_d     = '0;
          if (stock_q[4*i +: 4] == 4'd0) begin
            state_d = S_SOLDOUT;
            timer_d = MSG_CYCLES;
          end else if (bal_q < PRICE[16*i +: 16]) begin
            state_d = S_NOFUNDS;
            timer_d = MSG_CYCLES;
            msg_d   = PRICE[16*i +: 8];
          end else begin
            bal_d             = bcd_sub(bal_q, PRICE[16*i +: 16]);
            stock_d[4*i +: 4] = stock_q[4*i +: 4] - 4'd1;
            vend_d[i]         = 1'b1;
            state_d           = S_IDLE;
            timer_d           = '0;
          end
        end
      end
    end else if (one_rise || half_rise) begin
      if (coin_sum > {1'b0, MONEY_MAX}) begin
        rej_d = 1'b1;
      end else begin
        bal_d = coin_sum[15:0];
      end
      vend_d  = '0;
      state_d = S_IDLE;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bal_q     <= '0;
      stock_q   <= {N_ITEMS{STOCK_INIT}};
      msg_q     <= '0;
      vend_q    <= '0;
      chg_vld_q <= 1'b0;
      chg_amt_q <= '0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bal_q     <= bal_d;
      stock_q   <= stock_d;
      msg_q     <= msg_d;
      vend_q    <= vend_d;
      chg_vld_q <= chg_vld_d;
      chg_amt_q <= chg_amt_d;
      rej_q     <= rej_d;
    end
  end

  // Edge history tracks the inputs even during reset, so an edge that
  // coincides with reset is consumed rather than replayed afterwards.
  always_ff @(posedge clk) begin
    half_prev_q <= bus_io.halfyuan_i;
    one_prev_q  <= bus_io.oneyuan_i;
    sell_prev_q <= bus_io.sell_i;
    sup_prev_q  <= bus_io.supply_i;
    ret_prev_q  <= bus_io.coin_return_i;
  end

  always_comb begin
    bus_io.display_o = bal_q;
    case (state_q)
      S_NOFUNDS: bus_io.display_o = {8'hCC, msg_q};
      S_SOLDOUT: bus_io.display_o = 16'hFFFF;
      default:   bus_io.display_o = bal_q;
    endcase
  end

  assign bus_io.stock_out_o  = stock_q;
  assign bus_io.vend_led_o   = vend_q;
  assign bus_io.change_vld_o = chg_vld_q;
  assign bus_io.change_amt_o = chg_amt_q;
  assign bus_io.coin_rej_o   = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vend_ctrl_multi : directed scenarios plus randomized run against
//                      a behavioural money/stock model
// Rev 1.0
// ------------------------------------------------------------------
module tb_vend_ctrl_multi;
  localparam int N = 3;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.N_ITEMS(N)) bus ();

  vend_ctrl_multi #(
    .N_ITEMS   (N),
    .PRICE     ({16'h0035, 16'h0030, 16'h0020}),
    .STOCK_INIT(4'd5),
    .MONEY_MAX (16'h9995),
    .MSG_CYCLES(27'd8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: money as a plain integer count of 0.1-yuan units
  int             price_v [N] = '{20, 30, 35};
  int             m_bal;
  int             m_stock [N];
  int             m_state;      // 0 idle, 1 no funds, 2 sold out
  int             m_left;
  int             m_msg;
  logic [N-1:0]   m_vend;
  logic           m_cv;
  int             m_camt;
  logic           m_rej;
  logic           m_ph, m_po, m_psup, m_pret;
  logic [N-1:0]   m_ps;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [15:0] exp_display();
    logic [15:0] p;
    if (m_state == 1) begin
      p = to_bcd(m_msg);
      return {8'hCC, p[7:0]};
    end else if (m_state == 2) begin
      return 16'hFFFF;
    end
    return to_bcd(m_bal);
  endfunction

  function automatic logic [4*N-1:0] exp_stock();
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_stock[i]);
    return r;
  endfunction

  task automatic model_update(input logic h, input logic o, input logic [N-1:0] s,
                              input logic sup, input logic ret, input logic r);
    logic hr, orr, supr, retr;
    logic [N-1:0] sr;
    int idx, amt;
    if (r) begin
      m_bal = 0; m_state = 0; m_left = 0; m_msg = 0;
      for (int i = 0; i < N; i++) m_stock[i] = 5;
      m_vend = '0; m_cv = 1'b0; m_camt = 0; m_rej = 1'b0;
    end else begin
      hr = h & ~m_ph; orr = o & ~m_po; supr = sup & ~m_psup; retr = ret & ~m_pret;
      sr = s & ~m_ps;
      m_cv = 1'b0; m_rej = 1'b0;
      if (m_state != 0) begin
        m_left = m_left - 1;
        if (m_left <= 0) m_state = 0;
      end
      if (retr) begin
        m_camt = m_bal; m_cv = 1'b1; m_bal = 0; m_vend = '0; m_state = 0;
      end else if (supr) begin
        for (int i = 0; i < N; i++) m_stock[i] = 5;
        m_vend = '0; m_state = 0;
      end else if (sr != '0) begin
        idx = 0;
        while (!sr[idx]) idx++;
        m_vend = '0;
        if (m_stock[idx] == 0) begin
          m_state = 2; m_left = M;
        end else if (m_bal < price_v[idx]) begin
          m_state = 1; m_left = M; m_msg = price_v[idx];
        end else begin
          m_bal = m_bal - price_v[idx];
          m_stock[idx] = m_stock[idx] - 1;
          m_vend[idx] = 1'b1;
          m_state = 0;
        end
      end else if (orr || hr) begin
        amt = orr ? 10 : 5;
        if (m_bal + amt > 9995) m_rej = 1'b1;
        else m_bal = m_bal + amt;
        m_vend = '0; m_state = 0;
      end
    end
    m_ph = h; m_po = o; m_ps = s; m_psup = sup; m_pret = ret;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after
  task automatic step(input logic h, input logic o, input logic [N-1:0] s,
                      input logic sup, input logic ret, input logic r);
    bus.halfyuan_i    = h;
    bus.oneyuan_i     = o;
    bus.sell_i        = s;
    bus.supply_i      = sup;
    bus.coin_return_i = ret;
    rst               = r;
    @(posedge clk);
    model_update(h, o, s, sup, ret, r);
    #1;
  endtask

  task automatic idle();       step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_reset();   step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); endtask
  task automatic press_one();  step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0); idle(); endtask
  task automatic press_half(); step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0); idle(); endtask
  task automatic press_sell(input logic [N-1:0] s); step(1'b0, 1'b0, s, 1'b0, 1'b0, 1'b0); idle(); endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.display_o !== 16'h0000) $display("FAIL reset_display: got %h want 0000", bus.display_o); else n_pass++;
    n_total++; if (bus.stock_out_o !== 12'h555) $display("FAIL reset_stock: got %h want 555", bus.stock_out_o); else n_pass++;
    n_total++; if ({bus.vend_led_o, bus.change_vld_o, bus.coin_rej_o} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000", {bus.vend_led_o, bus.change_vld_o, bus.coin_rej_o}); else n_pass++;
    n_total++; if (bus.change_amt_o !== 16'h0000) $display("FAIL reset_change_amt: got %h want 0000", bus.change_amt_o); else n_pass++;
  endtask

  task automatic test_coins();
    do_reset();
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'h0010) $display("FAIL coin_latency: got %h want 0010", bus.display_o); else n_pass++;
    idle(); press_one(); press_one();
    n_total++; if (bus.display_o !== 16'h0030) $display("FAIL coins_display: got %h want 0030", bus.display_o); else n_pass++;
    n_total++; if (bus.stock_out_o !== 12'h555 || bus.vend_led_o !== 3'b000)
      $display("FAIL coins_stock_led: got %h/%b want 555/000", bus.stock_out_o, bus.vend_led_o); else n_pass++;
  endtask

  task automatic test_sell();
    step(1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'h0000) $display("FAIL sell_balance: got %h want 0000", bus.display_o); else n_pass++;
    n_total++; if (bus.stock_out_o !== 12'h545) $display("FAIL sell_stock: got %h want 545", bus.stock_out_o); else n_pass++;
    n_total++; if (bus.vend_led_o !== 3'b010) $display("FAIL sell_led: got %b want 010", bus.vend_led_o); else n_pass++;
    idle();
  endtask

  task automatic test_nofunds();
    int bad;
    do_reset(); press_one(); press_half();
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    bad = 0;
    if (bus.display_o !== 16'hCC35) bad++;
    for (int k = 1; k < M; k++) begin
      idle();
      if (bus.display_o !== 16'hCC35) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL nofunds_hold: got %0d bad cycles want 0", bad); else n_pass++;
    idle();
    n_total++; if (bus.display_o !== 16'h0015) $display("FAIL nofunds_expire: got %h want 0015", bus.display_o); else n_pass++;
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'h0025) $display("FAIL nofunds_abort: got %h want 0025", bus.display_o); else n_pass++;
    for (int k = 0; k < M + 2; k++) idle();
    n_total++; if (bus.display_o !== 16'h0025) $display("FAIL nofunds_after_abort: got %h want 0025", bus.display_o); else n_pass++;
  endtask

  task automatic test_soldout_supply();
    do_reset();
    for (int k = 0; k < 10; k++) press_one();
    for (int k = 0; k < 5; k++) press_sell(3'b001);
    n_total++; if (bus.stock_out_o !== 12'h550 || bus.display_o !== 16'h0000)
      $display("FAIL soldout_drain: got %h/%h want 550/0000", bus.stock_out_o, bus.display_o); else n_pass++;
    step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'hFFFF || bus.vend_led_o !== 3'b000)
      $display("FAIL soldout_msg: got %h/%b want FFFF/000", bus.display_o, bus.vend_led_o); else n_pass++;
    for (int k = 0; k < M; k++) idle();
    n_total++; if (bus.display_o !== 16'h0000) $display("FAIL soldout_expire: got %h want 0000", bus.display_o); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_total++; if (bus.stock_out_o !== 12'h555) $display("FAIL supply_stock: got %h want 555", bus.stock_out_o); else n_pass++;
    idle();
  endtask

  task automatic test_ceiling_return();
    do_reset();
    for (int k = 0; k < 999; k++) press_one();
    press_half();
    n_total++; if (bus.display_o !== 16'h9995) $display("FAIL ceiling_fill: got %h want 9995", bus.display_o); else n_pass++;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.coin_rej_o !== 1'b1 || bus.display_o !== 16'h9995)
      $display("FAIL ceiling_reject: got %b/%h want 1/9995", bus.coin_rej_o, bus.display_o); else n_pass++;
    idle();
    n_total++; if (bus.coin_rej_o !== 1'b0) $display("FAIL ceiling_rej_pulse: got %b want 0", bus.coin_rej_o); else n_pass++;
    step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    n_total++; if (bus.change_vld_o !== 1'b1 || bus.change_amt_o !== 16'h9995 || bus.display_o !== 16'h0000)
      $display("FAIL return_full: got %b/%h/%h want 1/9995/0000", bus.change_vld_o, bus.change_amt_o, bus.display_o); else n_pass++;
    idle();
    n_total++; if (bus.change_vld_o !== 1'b0 || bus.display_o !== 16'h0000)
      $display("FAIL return_pulse: got %b/%h want 0/0000", bus.change_vld_o, bus.display_o); else n_pass++;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_total++; if (bus.change_vld_o !== 1'b1 || bus.change_amt_o !== 16'h0000)
      $display("FAIL return_zero: got %b/%h want 1/0000", bus.change_vld_o, bus.change_amt_o); else n_pass++;
    idle();
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    for (int k = 0; k < 4; k++) press_one();
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'h0020 || bus.stock_out_o !== 12'h554)
      $display("FAIL hold_one_vend: got %h/%h want 0020/554", bus.display_o, bus.stock_out_o); else n_pass++;
    idle();
    step(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'hCC35) $display("FAIL hold_nofunds: got %h want CC35", bus.display_o); else n_pass++;
    do_reset();
    n_total++; if (bus.display_o !== 16'h0000) $display("FAIL reset_mid_msg: got %h want 0000", bus.display_o); else n_pass++;
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.display_o !== 16'h0000) $display("FAIL reset_eats_event: got %h want 0000", bus.display_o); else n_pass++;
    idle();
  endtask

  task automatic test_random();
    logic [N-1:0] s;
    logic [48:0]  got, want;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) s[i] = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, s,
           $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0);
      got  = {bus.display_o, bus.stock_out_o, bus.vend_led_o, bus.change_vld_o, bus.change_amt_o, bus.coin_rej_o};
      want = {exp_display(), exp_stock(), m_vend, m_cv, to_bcd(m_camt), m_rej};
      n_total++;
      if (got !== want) $display("FAIL random_cycle_%0d: got %h want %h", k, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    bus.halfyuan_i    = 1'b0;
    bus.oneyuan_i     = 1'b0;
    bus.sell_i        = '0;
    bus.supply_i      = 1'b0;
    bus.coin_return_i = 1'b0;
    m_ph = 1'b0; m_po = 1'b0; m_ps = '0; m_psup = 1'b0; m_pret = 1'b0;
    test_reset();
    test_coins();
    test_sell();
    test_nofunds();
    test_soldout_supply();
    test_ceiling_return();
    test_hold_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
